// File: rtl/eprom_pkg.sv
// Shared encodings for the EPROM program/erase sequencer.
package eprom_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_PGM_PULSE,
        S_PGM_VERIFY,
        S_ERASE_PULSE,
        S_BLANK_CHK,
        S_RESP
    } state_e;

    // Wide enough for any supported word; sliced to DATA_W at use.
    localparam logic [63:0] ERASED_WORD = '1;

endpackage

// File: rtl/eprom_pulse_timer.sv
// Loadable down-counter; done marks the final cycle of a pulse.
module eprom_pulse_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/eprom_prog_ctrl.sv
// Host command sequencer for the EPROM array: timed program/erase
// pulses followed by read-back verify or blank check.
module eprom_prog_ctrl
    import eprom_pkg::*;
#(
    parameter int ADDR_W           = 4,
    parameter int DATA_W           = 16,
    parameter int PGM_PULSE_CYCLES = 4,
    parameter int ERASE_CYCLES     = 8,
    parameter int MAX_RETRY        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_erase,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int PULSE_MAX =
        (PGM_PULSE_CYCLES > ERASE_CYCLES) ? PGM_PULSE_CYCLES : ERASE_CYCLES;
    localparam int CNT_W = $clog2(PULSE_MAX + 1);
    localparam int ATT_W = $clog2(MAX_RETRY + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [DATA_W-1:0] ONES = ERASED_WORD[DATA_W-1:0];

    state_e            state, state_n;
    logic [ATT_W-1:0]  attempts, attempts_n;
    logic [ATT_W-1:0]  attempts_inc;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [DATA_W-1:0] rdata_n;
    logic              err_n;
    logic              accept;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_done;

    assign accept       = cmd_valid & cmd_ready;
    assign attempts_inc = attempts + 1'b1;

    eprom_pulse_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    always_comb begin
        state_n    = state;
        attempts_n = attempts;
        addr_n     = mem_addr;
        wdata_n    = mem_write_data;
        rdata_n    = rsp_rdata;
        err_n      = rsp_err;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (op_e'(cmd_op))
                        OP_READ: begin
                            state_n = S_READ;
                            addr_n  = cmd_addr;
                            wdata_n = cmd_wdata;
                        end
                        OP_PROGRAM: begin
                            state_n    = S_PGM_PULSE;
                            addr_n     = cmd_addr;
                            wdata_n    = cmd_wdata;
                            attempts_n = '0;
                            tmr_load   = 1'b1;
                            tmr_val    = CNT_W'(PGM_PULSE_CYCLES);
                        end
                        OP_ERASE: begin
                            state_n  = S_ERASE_PULSE;
                            addr_n   = cmd_addr;
                            wdata_n  = cmd_wdata;
                            tmr_load = 1'b1;
                            tmr_val  = CNT_W'(ERASE_CYCLES);
                        end
                        OP_ILLEGAL: begin
                            // Rejected without touching any EPROM pin.
                            state_n = S_RESP;
                            err_n   = 1'b1;
                            rdata_n = '0;
                        end
                    endcase
                end
            end
            S_READ: begin
                state_n = S_RESP;
                rdata_n = mem_data;
                err_n   = 1'b0;
            end
            S_PGM_PULSE: begin
                if (tmr_done) state_n = S_PGM_VERIFY;
            end
            S_PGM_VERIFY: begin
                if (mem_data == mem_write_data) begin
                    state_n = S_RESP;
                    err_n   = 1'b0;
                    rdata_n = mem_write_data;
                end else begin
                    attempts_n = attempts_inc;
                    if (attempts_inc < ATT_W'(MAX_RETRY)) begin
                        state_n  = S_PGM_PULSE;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(PGM_PULSE_CYCLES);
                    end else begin
                        state_n = S_RESP;
                        err_n   = 1'b1;
                        rdata_n = DATA_W'(mem_addr);
                    end
                end
            end
            S_ERASE_PULSE: begin
                if (tmr_done) begin
                    state_n = S_BLANK_CHK;
                    addr_n  = '0;
                end
            end
            S_BLANK_CHK: begin
                if (mem_data != ONES) begin
                    state_n = S_RESP;
                    err_n   = 1'b1;
                    rdata_n = DATA_W'(mem_addr);
                end else if (mem_addr == LAST_ADDR) begin
                    state_n = S_RESP;
                    err_n   = 1'b0;
                    rdata_n = ONES;
                end else begin
                    addr_n = mem_addr + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Every pin is a register decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            attempts       <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
            mem_we         <= 1'b0;
            mem_erase      <= 1'b0;
        end else begin
            state          <= state_n;
            attempts       <= attempts_n;
            mem_addr       <= addr_n;
            mem_write_data <= wdata_n;
            rsp_rdata      <= rdata_n;
            rsp_err        <= err_n;
            cmd_ready      <= (state_n == S_IDLE);
            busy           <= (state_n != S_IDLE);
            rsp_valid      <= (state_n == S_RESP);
            mem_we         <= (state_n == S_PGM_PULSE);
            mem_erase      <= (state_n == S_ERASE_PULSE);
        end
    end

endmodule

// File: tb/tb_eprom_prog_ctrl.sv
// Bench for eprom_prog_ctrl: behavioural EPROM plus a command-level
// reference model, directed cases followed by random commands.
module tb_eprom_prog_ctrl;
    import eprom_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int PGM   = 4;
    localparam int ER    = 8;
    localparam int MR    = 3;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_write_data;
    logic          mem_erase;
    logic [DW-1:0] mem_data;

    int n_tests = 0;
    int n_fail  = 0;

    eprom_prog_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .PGM_PULSE_CYCLES(PGM),
        .ERASE_CYCLES(ER), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_write_data(mem_write_data), .mem_erase(mem_erase),
        .mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // EPROM model: words, optional stuck words, ignorable program pulses.
    logic [DW-1:0] mem [DEPTH];
    logic          stuck [DEPTH];
    logic [DW-1:0] stuck_val [DEPTH];
    int            ignore_left = 0;
    logic          ign_cur = 1'b0;
    logic          we_q = 1'b0;

    assign mem_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_erase) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= stuck[i] ? stuck_val[i] : 16'hFFFF;
        end else if (mem_we) begin
            if (!we_q) begin
                ign_cur = (ignore_left > 0);
                if (ign_cur) ignore_left = ignore_left - 1;
            end
            if (!ign_cur && !stuck[mem_addr])
                mem[mem_addr] <= mem_write_data;
        end
        we_q <= mem_we;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Command-level outcome derived from the array contents.
    task automatic predict(input logic [1:0] op, input logic [3:0] a,
                           input logic [15:0] wd, input int ign,
                           output logic e_err, output logic [15:0] e_rd,
                           output int e_lat, output int e_pul,
                           output int e_sweep);
        logic [15:0] cur;
        int k;
        int f;
        e_pul   = 0;
        e_sweep = 0;
        case (op)
            2'd0: begin
                e_err = 1'b0; e_rd = mem[a]; e_lat = 2;
            end
            2'd1: begin
                k = 0;
                for (int p = 1; p <= MR; p++) begin
                    cur = stuck[a] ? stuck_val[a] : ((p > ign) ? wd : mem[a]);
                    if (k == 0 && cur == wd) k = p;
                end
                if (k != 0) begin
                    e_err = 1'b0; e_rd = wd;
                    e_lat = 1 + k * (PGM + 1); e_pul = k;
                end else begin
                    e_err = 1'b1; e_rd = {12'h000, a};
                    e_lat = 1 + MR * (PGM + 1); e_pul = MR;
                end
            end
            2'd2: begin
                f = -1;
                for (int i = 0; i < DEPTH; i++) begin
                    cur = stuck[i] ? stuck_val[i] : 16'hFFFF;
                    if (f < 0 && cur != 16'hFFFF) f = i;
                end
                if (f < 0) begin
                    e_err = 1'b0; e_rd = 16'hFFFF;
                    e_lat = 1 + ER + DEPTH; e_sweep = DEPTH - 1;
                end else begin
                    e_err = 1'b1; e_rd = 16'(f);
                    e_lat = 1 + ER + f + 1; e_sweep = f;
                end
            end
            default: begin
                e_err = 1'b1; e_rd = 16'h0000; e_lat = 1;
            end
        endcase
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op,
                           input logic [3:0] a, input logic [15:0] wd,
                           input int ign, input int hold);
        logic        e_err;
        logic [15:0] e_rd;
        int e_lat, e_pul, e_sweep;
        int lat, wec, erc, pul, sweep, w;
        logic prev_we, er_seen, pin_bad, both, unstable;
        logic [15:0] rd0;
        logic err0;
        predict(op, a, wd, ign, e_err, e_rd, e_lat, e_pul, e_sweep);
        ignore_left = ign;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr = 4'($urandom);
        cmd_wdata = 16'($urandom);
        lat = 1; wec = 0; erc = 0; pul = 0; sweep = 0;
        prev_we = 0; er_seen = 0; pin_bad = 0; both = 0;
        while (!rsp_valid && lat < 100) begin
            if (mem_we) wec++;
            if (mem_we && !prev_we) pul++;
            prev_we = mem_we;
            if (mem_erase) begin
                erc++; er_seen = 1'b1;
            end else if (er_seen && int'(mem_addr) > sweep) begin
                sweep = int'(mem_addr);
            end
            if ((mem_we || mem_erase) && mem_addr !== a) pin_bad = 1'b1;
            if (mem_we && mem_write_data !== wd) pin_bad = 1'b1;
            if (mem_we && mem_erase) both = 1'b1;
            @(posedge clk); #1; lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        chk({tag, " err"}, 32'(rsp_err), 32'(e_err));
        chk({tag, " rdata"}, 32'(rsp_rdata), 32'(e_rd));
        chk({tag, " we_cycles"}, 32'(wec), 32'(e_pul * PGM));
        chk({tag, " pulses"}, 32'(pul), 32'(e_pul));
        chk({tag, " erase_cycles"}, 32'(erc), (op == 2'd2) ? 32'(ER) : 32'd0);
        chk({tag, " pin_stable"}, 32'(pin_bad), 32'd0);
        chk({tag, " we_erase_excl"}, 32'(both), 32'd0);
        if (op == 2'd2) chk({tag, " sweep_end"}, 32'(sweep), 32'(e_sweep));
        rd0 = rsp_rdata; err0 = rsp_err; unstable = 1'b0;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            if (!rsp_valid || cmd_ready || !busy || rsp_rdata !== rd0 ||
                rsp_err !== err0)
                unstable = 1'b1;
        end
        if (hold > 0) chk({tag, " hold"}, 32'(unstable), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " done"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
    endtask

    initial begin
        logic [1:0]  op;
        logic [3:0]  a;
        int          stray;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 16'($urandom);
            stuck[i] = 1'b0;
            stuck_val[i] = '0;
        end
        mem[5] <= 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs",
            {22'd0, cmd_ready, rsp_valid, rsp_err, busy, mem_we, mem_erase,
             mem_addr}, 32'h200);
        chk("reset data", {rsp_rdata, mem_write_data}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd("read5", OP_READ, 4'd5, 16'h0, 0, 0);
        run_cmd("pgm3", OP_PROGRAM, 4'd3, 16'h00AA, 0, 1);
        run_cmd("read3", OP_READ, 4'd3, 16'h0, 0, 0);
        mem[10] <= 16'h0000;
        @(negedge clk);
        run_cmd("pgm10_retry", OP_PROGRAM, 4'd10, 16'h0022, 2, 0);
        mem[10] <= 16'h0000;
        @(negedge clk);
        run_cmd("pgm10_fail", OP_PROGRAM, 4'd10, 16'h0022, 3, 0);
        run_cmd("erase_ok", OP_ERASE, 4'd9, 16'h0, 0, 0);
        stuck[7] = 1'b1; stuck_val[7] = 16'hFFFE;
        run_cmd("erase_stuck7", OP_ERASE, 4'd2, 16'h0, 0, 0);
        stuck[7] = 1'b0;
        run_cmd("illegal", OP_ILLEGAL, 4'd6, 16'h5555, 0, 5);

        // Abort an erase in its second pulse cycle.
        cmd_valid = 1'b1; cmd_op = OP_ERASE; cmd_addr = 4'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort erase_on", 32'(mem_erase), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort pins", {29'd0, mem_erase, busy, cmd_ready}, 32'b001);
        stray = 0;
        repeat (4) begin
            if (rsp_valid || mem_erase) stray++;
            @(posedge clk); #1;
        end
        chk("abort no_rsp", 32'(stray), 32'd0);
        run_cmd("read_after_abort", OP_READ, 4'd5, 16'h0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom);
            if (op == 2'd2 && $urandom_range(0, 2) == 0) begin
                stuck[$urandom_range(0, DEPTH - 1)] = 1'b1;
                for (int i = 0; i < DEPTH; i++)
                    if (stuck[i]) stuck_val[i] = 16'hFFFF ^ (16'h1 << $urandom_range(0, 15));
            end
            run_cmd($sformatf("rnd%0d", n), op, a, 16'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            for (int i = 0; i < DEPTH; i++) stuck[i] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
